fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction memory.
- Owns the program counter, drives the memory address, and captures the returned 16-bit word into an output register.
- Hands the captured word to decode over a valid/ready handshake.
- Supports decode stall, branch/jump redirect with flush, start from reset, and halt on a designated instruction word.

Parameters:
- WORD, 16, instruction width in bits.
- PCL, 10, program counter / memory address width.
- NOP, 16'b1000000001000000, bubble word driven on instr_out when empty or flushed.
- HALT_WORD, 16'hFFFF, instruction encoding that stops fetch.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins fetch from address 0.
- imem_addr  output  PCL  address to instruction memory; always equals pc.
- imem_data  input  WORD  memory read data; combinational, valid in the same cycle as imem_addr.
- redirect  input  1  branch/jump taken; loads pc and flushes.
- redirect_target  input  PCL  new pc when redirect=1.
- instr_out  output  WORD  registered instruction to decode.
- pc_out  output  PCL  address instr_out was fetched from.
- valid_out  output  1  instr_out/pc_out hold a live instruction.
- ready_in  input  1  decode accepts this cycle.
- halted  output  1  high in HALTED state.
- fetch_count  output  16  count of instructions accepted by decode.

Behaviour:
- Reset (asynchronous, immediate on rst=1, including mid-operation):
  - state=IDLE, pc=0.
  - instr_out=NOP, pc_out=0, valid_out=0, halted=0, fetch_count=0.
- States: IDLE, RUN, HALTED.
- IDLE:
  - No loads; redirect ignored.
  - start=1 -> RUN next cycle with pc=0.
- RUN: define fire = valid_out && ready_in, and load = !valid_out || ready_in.
  - load=1 at clock edge: instr_out<=imem_data, pc_out<=pc, valid_out<=1, pc<=pc+1.
  - Latency: the word at address A appears on instr_out one cycle after pc=A.
  - Stall (valid_out=1, ready_in=0): pc, instr_out, pc_out and valid_out all hold. The offered instruction must not change while stalled.
  - pc increment is modulo 2^PCL: 1023 -> 0, no flag.
  - Halt: if load=1 and imem_data==HALT_WORD, the word is loaded normally (valid_out<=1, pc_out<=pc). pc is not incremented, and state -> HALTED.
- HALTED:
  - halted=1; no further loads.
  - valid_out clears on fire, after which instr_out<=NOP.
- Redirect (RUN or HALTED), highest priority over load, halt and stall:
  - pc<=redirect_target, valid_out<=0, instr_out<=NOP, pc_out holds.
  - State -> RUN; halted<=0.
  - Fetch from the target begins the next cycle.
  - If fire and redirect occur in the same cycle, the accepted instruction counts and the flush still applies.
- fetch_count increments by 1 on every fire, in any state. It saturates at 16'hFFFF.
- start while in RUN or HALTED is ignored.
- imem_addr = pc combinationally, in all states.

Test Plan:
- Reset, start, memory holds 0x1000+A at address A, ready_in=1 constant -> from cycle 2 instr_out = 0x1000, 0x1001, 0x1002… with pc_out 0,1,2; fetch_count increments each cycle.
- ready_in=0 for 3 cycles while instr_out=0x1005 -> instr_out, pc_out=5, valid_out=1 and pc=6 all held. On release, 0x1006 follows the next cycle with no skip or duplicate.
- redirect=1, target=0x200, while a stalled instruction is valid -> the next cycle has valid_out=0 and instr_out=NOP; the following cycle has pc_out=0x200 and fetch_count unchanged.
- Start pc near end via redirect to 0x3FE -> fetch sequence 0x3FE, 0x3FF, 0x000; pc_out wraps cleanly.
- HALT_WORD at address 4 -> HALT_WORD delivered with pc_out=4 and halted=1; valid_out drops after acceptance; pc stays 4. A later redirect to 0 resumes RUN with halted=0.
- Assert rst mid-stall -> all outputs reach their reset values without a clock edge. Start is required to resume from address 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect request, and the
// valid/ready handoff of the fetched word to decode.
interface fetch_unit_if #(
    parameter int WORD = 16,
    parameter int PCL  = 10
);
    logic [PCL-1:0]  imem_addr;
    logic [WORD-1:0] imem_data;
    logic            redirect;
    logic [PCL-1:0]  redirect_target;
    logic [WORD-1:0] instr_out;
    logic [PCL-1:0]  pc_out;
    logic            valid_out;
    logic            ready_in;

    modport master (
        output imem_addr, instr_out, pc_out, valid_out,
        input  imem_data, redirect, redirect_target, ready_in
    );

    modport slave (
        input  imem_addr, instr_out, pc_out, valid_out,
        output imem_data, redirect, redirect_target, ready_in
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns pc, reads combinational imem, registers the word for
// decode over valid/ready, with redirect flush and halt on a marker word.
//
// state  | meaning
// IDLE   | out of reset, waiting for start; no fetches
// RUN    | fetching sequentially from pc
// HALTED | halt word fetched; last word drains, no new fetches
module fetch_unit #(
    parameter int              WORD      = 16,
    parameter int              PCL       = 10,
    parameter logic [WORD-1:0] NOP       = 16'b1000000001000000,
    parameter logic [WORD-1:0] HALT_WORD = 16'hFFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    fetch_unit_if.master fif,
    output logic         halted,
    output logic [15:0]  fetch_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [PCL-1:0]  pc, pc_n;
    logic [WORD-1:0] instr_q, instr_n;
    logic [PCL-1:0]  pc_out_q, pc_out_n;
    logic            valid_q, valid_n;
    logic [15:0]     count_q, count_n;
    logic            fire;
    logic            load;

    assign fire = valid_q && fif.ready_in;
    assign load = !valid_q || fif.ready_in;

    assign fif.imem_addr = pc;
    assign fif.instr_out = instr_q;
    assign fif.pc_out    = pc_out_q;
    assign fif.valid_out = valid_q;
    assign halted        = (state == HALTED);
    assign fetch_count   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            instr_q  <= NOP;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            instr_q  <= instr_n;
            pc_out_q <= pc_out_n;
            valid_q  <= valid_n;
            count_q  <= count_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        instr_n  = instr_q;
        pc_out_n = pc_out_q;
        valid_n  = valid_q;
        count_n  = count_q;

        // An accepted word counts even when a redirect flushes in the same cycle.
        if (fire && count_q != 16'hFFFF) begin
            count_n = count_q + 16'd1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    pc_n    = '0;
                end
            end
            RUN: begin
                if (fif.redirect) begin
                    pc_n    = fif.redirect_target;
                    valid_n = 1'b0;
                    instr_n = NOP;
                end else if (load) begin
                    instr_n  = fif.imem_data;
                    pc_out_n = pc;
                    valid_n  = 1'b1;
                    if (fif.imem_data == HALT_WORD) begin
                        state_n = HALTED;
                    end else begin
                        pc_n = pc + PCL'(1);
                    end
                end
            end
            HALTED: begin
                if (fif.redirect) begin
                    state_n = RUN;
                    pc_n    = fif.redirect_target;
                    valid_n = 1'b0;
                    instr_n = NOP;
                end else if (fire) begin
                    valid_n = 1'b0;
                    instr_n = NOP;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through the fetch scenarios, then
// randomized traffic against a rule-level reference model.
module tb_fetch_unit;

    localparam logic [15:0] NOP       = 16'b1000000001000000;
    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halted;
    logic [15:0] fetch_count;
    logic [15:0] mem [1024];

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit_if #(.WORD(16), .PCL(10)) fif ();

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .fif         (fif),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    assign fif.imem_data = mem[fif.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input int ins, input int pco, input int v,
                        input int h, input int cnt, input int addr);
        chk({tag, ".instr"},  32'(fif.instr_out),   ins);
        chk({tag, ".pc_out"}, 32'(fif.pc_out),      pco);
        chk({tag, ".valid"},  32'(fif.valid_out),   v);
        chk({tag, ".halted"}, 32'(halted),          h);
        chk({tag, ".count"},  32'(fetch_count),     cnt);
        chk({tag, ".addr"},   32'(fif.imem_addr),   addr);
    endtask

    // Reference model: what decode should see, derived from the fetch rules.
    logic        m_active;
    logic        m_halted;
    logic [9:0]  m_pc;
    logic        m_valid;
    logic [15:0] m_instr;
    logic [9:0]  m_pcout;
    int          m_count;

    task automatic model_reset();
        m_active = 1'b0;
        m_halted = 1'b0;
        m_pc     = '0;
        m_valid  = 1'b0;
        m_instr  = NOP;
        m_pcout  = '0;
        m_count  = 0;
    endtask

    task automatic model_step();
        logic        accepted;
        logic [15:0] word;
        accepted = m_valid && fif.ready_in;
        if (accepted && m_count < 65535) m_count = m_count + 1;
        if (!m_active && !m_halted) begin
            if (start) begin
                m_active = 1'b1;
                m_pc     = '0;
            end
        end else if (fif.redirect) begin
            m_pc     = fif.redirect_target;
            m_valid  = 1'b0;
            m_instr  = NOP;
            m_active = 1'b1;
            m_halted = 1'b0;
        end else if (m_halted) begin
            if (accepted) begin
                m_valid = 1'b0;
                m_instr = NOP;
            end
        end else if (!m_valid || fif.ready_in) begin
            word    = mem[m_pc];
            m_instr = word;
            m_pcout = m_pc;
            m_valid = 1'b1;
            if (word == HALT_WORD) begin
                m_halted = 1'b1;
                m_active = 1'b0;
            end else begin
                m_pc = (m_pc == 10'h3FF) ? 10'h000 : m_pc + 10'd1;
            end
        end
    endtask

    task automatic model_cmp(input string tag);
        outs(tag, int'(m_instr), int'(m_pcout), int'(m_valid), int'(m_halted), m_count, int'(m_pc));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        fif.ready_in = 1'b1;
        fif.redirect = 1'b0;
        fif.redirect_target = '0;
        for (int a = 0; a < 1024; a++) mem[a] = 16'h1000 + 16'(a);

        repeat (2) @(negedge clk);
        outs("reset", int'(NOP), 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        outs("idle", int'(NOP), 0, 0, 0, 0, 0);
        fif.redirect = 1'b1;
        fif.redirect_target = 10'h155;
        @(negedge clk);
        outs("idle_redir", int'(NOP), 0, 0, 0, 0, 0);
        fif.redirect = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        outs("started", int'(NOP), 0, 0, 0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            outs("seq", 'h1000 + k, k, 1, 0, k, k + 1);
        end

        fif.ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            outs("stall", 'h1005, 5, 1, 0, 5, 6);
        end
        fif.ready_in = 1'b1;
        @(negedge clk);
        outs("release", 'h1006, 6, 1, 0, 6, 7);

        fif.ready_in = 1'b0;
        @(negedge clk);
        outs("stall2", 'h1006, 6, 1, 0, 6, 7);
        fif.redirect = 1'b1;
        fif.redirect_target = 10'h200;
        @(negedge clk);
        outs("flush", int'(NOP), 6, 0, 0, 6, 'h200);
        fif.redirect = 1'b0;
        fif.ready_in = 1'b1;
        @(negedge clk);
        outs("target", 'h1200, 'h200, 1, 0, 6, 'h201);

        // Accept and redirect in the same cycle: count still advances.
        fif.redirect = 1'b1;
        fif.redirect_target = 10'h3FE;
        @(negedge clk);
        outs("fire_flush", int'(NOP), 'h200, 0, 0, 7, 'h3FE);
        fif.redirect = 1'b0;
        @(negedge clk);
        outs("wrap0", 'h13FE, 'h3FE, 1, 0, 7, 'h3FF);
        @(negedge clk);
        outs("wrap1", 'h13FF, 'h3FF, 1, 0, 8, 0);
        @(negedge clk);
        outs("wrap2", 'h1000, 0, 1, 0, 9, 1);

        mem[4] = HALT_WORD;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            outs("pre_halt", 'h1000 + k, k, 1, 0, 9 + k, k + 1);
        end
        @(negedge clk);
        outs("halt", int'(HALT_WORD), 4, 1, 1, 13, 4);
        @(negedge clk);
        outs("halt_acc", int'(NOP), 4, 0, 1, 14, 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        outs("halt_start", int'(NOP), 4, 0, 1, 14, 4);
        fif.redirect = 1'b1;
        fif.redirect_target = 10'h000;
        @(negedge clk);
        outs("resume", int'(NOP), 4, 0, 0, 14, 0);
        fif.redirect = 1'b0;
        @(negedge clk);
        outs("resume1", 'h1000, 0, 1, 0, 14, 1);

        fif.ready_in = 1'b0;
        @(negedge clk);
        outs("pre_rst", 'h1000, 0, 1, 0, 14, 1);
        #2 rst = 1'b1;
        #1 outs("async_rst", int'(NOP), 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        fif.ready_in = 1'b1;
        repeat (2) begin
            @(negedge clk);
            outs("post_rst_idle", int'(NOP), 0, 0, 0, 0, 0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        outs("restart", 'h1000, 0, 1, 0, 0, 1);

        // Randomized traffic with halts sprinkled through memory.
        for (int a = 0; a < 1024; a++)
            mem[a] = ($urandom_range(0, 31) == 0) ? HALT_WORD : 16'($urandom);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(negedge clk);
            model_cmp("rand");
            if (cyc == 450) begin
                #2 rst = 1'b1;
                model_reset();
                #1 model_cmp("rand_rst");
                @(negedge clk);
                rst = 1'b0;
                model_cmp("rand_rst_rel");
            end
            start               = ($urandom_range(0, 7) == 0);
            fif.ready_in        = ($urandom_range(0, 3) != 0);
            fif.redirect        = ($urandom_range(0, 19) == 0);
            fif.redirect_target = 10'($urandom_range(0, 1023));
            model_step();
        end
        @(negedge clk);
        model_cmp("rand_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
